// File: rtl/responder_resolver.sv
// Multiple-response resolver: snapshots a tag vector and hands out responders lowest index first.
// Optional remaining-responder counter enabled by defining RESOLVER_COUNT_EN.
module responder_resolver #(
  parameter int WORDS = 5,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WORDS-1:0] tags_in_i,
  input  logic             load_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] index_o,
  output logic [WORDS-1:0] served_o,
  output logic             some_none_o,
  output logic             done_o,
  output logic [IDX_W:0]   count_o
);

  typedef enum logic {IDLE = 1'b0, ITER = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WORDS-1:0] pending_q, pending_d;
  logic             done_q, done_d;
  logic             some_q, some_d;
  logic             valid_s;
  logic             hs_s;
  logic [WORDS-1:0] low_bit_s;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [WORDS-1:0] v);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign valid_s   = (state_q == ITER) && (|pending_q);
  assign hs_s      = valid_s && ready_i && !load_i;
  // Isolates the lowest set bit of pending (zero when pending is empty).
  assign low_bit_s = pending_q & ~(pending_q - {{(WORDS-1){1'b0}}, 1'b1});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= {WORDS{1'b0}};
      done_q    <= 1'b0;
      some_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      some_q    <= some_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    some_d    = some_q;
    if (load_i) begin
      pending_d = tags_in_i;
      some_d    = |tags_in_i;
      state_d   = (|tags_in_i) ? ITER : IDLE;
      done_d    = ~(|tags_in_i);
    end else if (hs_s) begin
      pending_d = pending_q & ~low_bit_s;
      if (pending_d == {WORDS{1'b0}}) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = ITER;
      end
    end else begin
      state_d = state_q;
    end
  end

`ifdef RESOLVER_COUNT_EN
  logic [IDX_W:0] cnt_q, cnt_d;

  function automatic logic [IDX_W:0] popcount(input logic [WORDS-1:0] v);
    logic [IDX_W:0] c;
    c = {(IDX_W+1){1'b0}};
    for (int i = 0; i < WORDS; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {(IDX_W+1){1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = popcount(tags_in_i);
    end else if (hs_s) begin
      cnt_d = cnt_q - {{IDX_W{1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign count_o = cnt_q;
`else
  assign count_o = {(IDX_W+1){1'b0}};
`endif

  always_comb begin
    valid_o     = valid_s;
    index_o     = lowest_idx(pending_q);
    served_o    = hs_s ? low_bit_s : {WORDS{1'b0}};
    some_none_o = some_q;
    done_o      = done_q;
  end

endmodule

// File: tb/tb_responder_resolver.sv
// Self-checking bench for responder_resolver: directed scenarios plus random traffic vs. a queue model.
module tb_responder_resolver;
  logic       clk;
  logic       rst;
  logic [4:0] tags_in_i;
  logic       load_i;
  logic       ready_i;
  logic       valid_o;
  logic [2:0] index_o;
  logic [4:0] served_o;
  logic       some_none_o;
  logic       done_o;
  logic [3:0] count_o;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of responding word numbers in service order.
  int q[$];
  bit done_m;
  bit some_m;

  responder_resolver #(.WORDS(5), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .tags_in_i(tags_in_i), .load_i(load_i), .ready_i(ready_i),
    .valid_o(valid_o), .index_o(index_o), .served_o(served_o),
    .some_none_o(some_none_o), .done_o(done_o), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int v, idx, srv, cnt;
    v   = (q.size() > 0) ? 1 : 0;
    idx = v ? q[0] : 0;
    srv = (v && ready_i && !load_i) ? (1 << q[0]) : 0;
`ifdef RESOLVER_COUNT_EN
    cnt = q.size();
`else
    cnt = 0;
`endif
    chk("valid", int'(valid_o), v);
    chk("index", int'(index_o), idx);
    chk("served", int'(served_o), srv);
    chk("some_none", int'(some_none_o), int'(some_m));
    chk("done", int'(done_o), int'(done_m));
    chk("count", int'(count_o), cnt);
  endtask

  task automatic model_edge(input bit ld, input logic [4:0] tg, input bit rdy);
    bit was_valid;
    was_valid = (q.size() > 0);
    done_m = 1'b0;
    if (ld) begin
      q.delete();
      for (int i = 0; i < 5; i++) if (tg[i]) q.push_back(i);
      some_m = (tg != 5'd0);
      done_m = (tg == 5'd0);
    end else if (was_valid && rdy) begin
      void'(q.pop_front());
      if (q.size() == 0) done_m = 1'b1;
    end
  endtask

  // One clock cycle: drive inputs, check mid-cycle, advance model at the edge.
  task automatic cyc(input bit ld, input logic [4:0] tg, input bit rdy);
    load_i = ld; tags_in_i = tg; ready_i = rdy;
    #3;
    check_all();
    @(posedge clk);
    model_edge(ld, tg, rdy);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    done_m = 1'b0;
    some_m = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_i = 1'b0; ready_i = 1'b0; tags_in_i = 5'd0;
    model_reset();
    #12;
    check_all();
    rst = 1'b0;
    @(posedge clk); #1;
    cyc(1'b0, 5'd0, 1'b1);

    // Asynchronous reset in the middle of a pass.
    cyc(1'b1, 5'b10110, 1'b0);
    cyc(1'b0, 5'd0, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    cyc(1'b0, 5'd0, 1'b1);
    cyc(1'b0, 5'd0, 1'b1);

    // Zero-bubble drain.
    cyc(1'b1, 5'b10110, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 5'd0, 1'b1);

    // Empty snapshot.
    cyc(1'b1, 5'b00000, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 5'd0, 1'b1);

    // All responders with ready toggling.
    cyc(1'b1, 5'b11111, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 5'd0, (i % 2) == 0);

    // Reload during a handshake cycle.
    cyc(1'b1, 5'b00011, 1'b0);
    cyc(1'b1, 5'b01000, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 5'd0, 1'b1);

    // Random traffic, including reloads of tags_in outside load.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 5) == 0, 5'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
